// File: rtl/imem_loader.sv
// Boot loader: framed byte stream -> little-endian 32-bit words -> instruction memory, core held in reset until verified.
// Optional idle timeout is built only when IMEM_LOADER_TIMEOUT_EN is defined.
module imem_loader #(
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              core_reset_n,
    output logic              done,
    output logic              error,
    output logic [15:0]       word_count,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CHK, S_DONE, S_ERROR
    } state_t;

    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

    state_t              state_q, state_d;
    logic [15:0]         len_q, len_d;
    logic [7:0]          chk_q, chk_d;
    logic [1:0]          lane_q, lane_d;
    logic [31:0]         word_q, word_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [31:0]         wr_data_q, wr_data_d;
    logic [15:0]         count_q, count_d;
    logic                in_ready_q, in_ready_d;
    logic                accept;
`ifdef IMEM_LOADER_TIMEOUT_EN
    logic [15:0]         idle_q, idle_d;
`endif

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        chk_d     = chk_q;
        lane_d    = lane_q;
        word_d    = word_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        count_d   = count_q;
        accept    = in_valid && in_ready_q;

        // Address moves on only after the write it labelled; the last word keeps N-1.
        if (wr_en_q && state_q == S_DATA) begin
            wr_addr_d = wr_addr_q + ADDR_W'(1);
        end

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d   = S_LEN0;
                    chk_d     = 8'd0;
                    count_d   = 16'd0;
                    wr_addr_d = '0;
                    lane_d    = 2'd0;
                end
            end
            S_LEN0: begin
                if (accept) begin
                    len_d[7:0] = in_data;
                    chk_d      = chk_q ^ in_data;
                    state_d    = S_LEN1;
                end
            end
            S_LEN1: begin
                if (accept) begin
                    len_d[15:8] = in_data;
                    chk_d       = chk_q ^ in_data;
                    if ({1'b0, in_data, len_q[7:0]} > MAX_WORDS) begin
                        state_d = S_ERROR;
                    end else if ({in_data, len_q[7:0]} == 16'd0) begin
                        state_d = S_CHK;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    chk_d  = chk_q ^ in_data;
                    word_d = {in_data, word_q[31:8]};
                    lane_d = lane_q + 2'd1;
                    if (lane_q == 2'd3) begin
                        wr_en_d   = 1'b1;
                        wr_data_d = {in_data, word_q[31:8]};
                        count_d   = count_q + 16'd1;
                        if (count_q == len_q - 16'd1) begin
                            state_d = S_CHK;
                        end
                    end
                end
            end
            S_CHK: begin
                if (accept) begin
                    state_d = (in_data == chk_q) ? S_DONE : S_ERROR;
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef IMEM_LOADER_TIMEOUT_EN
        idle_d = 16'd0;
        if (state_q == S_LEN0 || state_q == S_LEN1 || state_q == S_DATA || state_q == S_CHK) begin
            if (accept || state_d != state_q) begin
                idle_d = 16'd0;
            end else if (idle_q == 16'(TIMEOUT_CYCLES)) begin
                state_d = S_ERROR;
            end else begin
                idle_d = idle_q + 16'd1;
            end
        end
`endif

        in_ready_d = (state_d == S_LEN0) || (state_d == S_LEN1) ||
                     (state_d == S_DATA) || (state_d == S_CHK);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            len_q        <= 16'd0;
            chk_q        <= 8'd0;
            lane_q       <= 2'd0;
            word_q       <= 32'd0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= 32'd0;
            count_q      <= 16'd0;
            in_ready_q   <= 1'b0;
            core_reset_n <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
`ifdef IMEM_LOADER_TIMEOUT_EN
            idle_q       <= 16'd0;
`endif
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            chk_q        <= chk_d;
            lane_q       <= lane_d;
            word_q       <= word_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            count_q      <= count_d;
            in_ready_q   <= in_ready_d;
            core_reset_n <= (state_d == S_DONE);
            done         <= (state_d == S_DONE);
            error        <= (state_d == S_ERROR);
`ifdef IMEM_LOADER_TIMEOUT_EN
            idle_q       <= idle_d;
`endif
        end
    end

    assign in_ready   = in_ready_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign word_count = count_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: random framed loads against a frame-level reference model with a write scoreboard.
module tb_imem_loader;
    localparam int ADDR_W = 8;
`ifdef IMEM_LOADER_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1024;
`endif

    logic              clk;
    logic              reset;
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              core_reset_n;
    logic              done;
    logic              error;
    logic [15:0]       word_count;
    logic [2:0]        dbg_state;

    int checks = 0;
    int errors = 0;
    logic [ADDR_W+31:0] exp_q[$];

    imem_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .core_reset_n(core_reset_n), .done(done), .error(error),
        .word_count(word_count), .dbg_state(dbg_state)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the next expected (addr, data)
    always @(negedge clk) begin
        if (reset === 1'b1 && wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %08h expected no write", wr_addr, wr_data);
            end else begin
                check("write", {24'd0, wr_addr, wr_data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    // Reference model: frame bytes and the writes a correct loader makes
    task automatic build_frame(input logic [31:0] words[$], input logic [15:0] n_len, input bit bad,
                               output logic [7:0] fr[$]);
        logic [7:0] x;
        fr.delete();
        fr.push_back(n_len[7:0]);
        fr.push_back(n_len[15:8]);
        foreach (words[i]) begin
            for (int b = 0; b < 4; b++) fr.push_back(8'((words[i] >> (8 * b)) & 32'hFF));
        end
        x = 8'd0;
        foreach (fr[i]) x = x ^ fr[i];
        fr.push_back(bad ? (x ^ 8'h01) : x);
    endtask

    task automatic push_writes(input logic [31:0] words[$]);
        foreach (words[i]) exp_q.push_back({ADDR_W'(i), words[i]});
    endtask

    // Drivers
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        logic rdy;
        int guard;
        if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        guard    = 0;
        forever begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk); #1;
            if (rdy) break;
            guard++;
            if (guard > 20) begin
                checks++;
                errors++;
                $display("FAIL byte_accept: in_ready stayed 0 for byte %02h", b);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send_bytes(input logic [7:0] fr[$], input bit gaps);
        foreach (fr[i]) send_byte(fr[i], gaps);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        check({tag, "_wr_en"}, 64'(wr_en), 64'd0);
        check({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
        check({tag, "_wr_data"}, 64'(wr_data), 64'd0);
        check({tag, "_core_reset_n"}, 64'(core_reset_n), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_error"}, 64'(error), 64'd0);
        check({tag, "_word_count"}, 64'(word_count), 64'd0);
    endtask

    // Full load of a legal-length image, then frame-level result checks
    task automatic run_frame(input string tag, input logic [31:0] words[$], input bit bad, input bit gaps);
        logic [7:0] fr[$];
        int n;
        n = words.size();
        build_frame(words, 16'(n), bad, fr);
        push_writes(words);
        pulse_start();
        send_bytes(fr, gaps);
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_done"}, 64'(done), bad ? 64'd0 : 64'd1);
        check({tag, "_error"}, 64'(error), bad ? 64'd1 : 64'd0);
        check({tag, "_core_reset_n"}, 64'(core_reset_n), bad ? 64'd0 : 64'd1);
        check({tag, "_word_count"}, 64'(word_count), 64'(n));
        check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        check({tag, "_wr_addr"}, 64'(wr_addr), (n > 0) ? 64'(n - 1) : 64'd0);
    endtask

    logic [31:0] good_words[$];
    logic [31:0] rw[$];
    logic [7:0]  fr[$];

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        good_words = '{32'h00500113, 32'h00C00193};
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("por");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        // Known frame: 02 00 13 01 50 00 93 01 C0 00 12
        build_frame(good_words, 16'd2, 1'b0, fr);
        check("frame_chk_byte", 64'(fr[10]), 64'h12);
        run_frame("good", good_words, 1'b0, 1'b0);
        run_frame("badchk", good_words, 1'b1, 1'b0);
        rw.delete();
        run_frame("empty", rw, 1'b0, 1'b0);

        // Oversize: N = 0x0101 must error as soon as LEN_HI is taken
        pulse_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h01, 1'b0);
        check("oversize_error", 64'(error), 64'd1);
        check("oversize_in_ready", 64'(in_ready), 64'd0);
        check("oversize_done", 64'(done), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("oversize_wc", 64'(word_count), 64'd0);

        run_frame("bp", good_words, 1'b0, 1'b1);

        // Reset after 5 bytes of a good frame
        pulse_start();
        for (int i = 0; i < 5; i++) send_byte(fr[i], 1'b1);
        reset = 1'b0;
        #1;
        check_reset_vals("midreset");
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        run_frame("after_reset", good_words, 1'b0, 1'b1);

        // Random images
        for (int t = 0; t < 8; t++) begin
            rw.delete();
            repeat ($urandom_range(0, 6)) rw.push_back($urandom());
            run_frame($sformatf("rand%0d", t), rw, ($urandom_range(0, 3) == 0), 1'b1);
        end

        // Full-capacity image: last address is 2^ADDR_W-1
        rw.delete();
        for (int i = 0; i < (1 << ADDR_W); i++) rw.push_back($urandom());
        run_frame("max", rw, 1'b0, 1'b0);

        // Stall in DATA after 3 bytes
        pulse_start();
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h13, 1'b0);
`ifdef IMEM_LOADER_TIMEOUT_EN
        repeat (TO) @(posedge clk);
        #1;
        check("timeout_early", 64'(error), 64'd0);
        @(posedge clk); #1;
        check("timeout_error", 64'(error), 64'd1);
        check("timeout_in_ready", 64'(in_ready), 64'd0);
`else
        repeat (40) @(posedge clk);
        #1;
        check("stall_error", 64'(error), 64'd0);
        check("stall_in_ready", 64'(in_ready), 64'd1);
        check("stall_done", 64'(done), 64'd0);
`endif
        reset = 1'b0;
        #1;
        check_reset_vals("final_reset");
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the core's instruction memory; the core's fetch stage is the reader.
- Accepts a framed byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes each word sequentially into the instruction memory write port from word address 0.
- Holds the core in reset until a complete, checksum-verified image has been written.

Parameters:
- ADDR_W, 8, instruction memory word-address width; capacity is 2^ADDR_W words.
- TIMEOUT_CYCLES, 1024, idle-cycle limit between accepted bytes; used only when IMEM_LOADER_TIMEOUT_EN is defined.

Ports:
- clk  input  1  system clock
- reset  input  1  one clock; reset is asynchronous and active-low
- start  input  1  one-cycle pulse; arms the loader from IDLE, DONE or ERROR
- in_valid  input  1  byte-stream valid
- in_data  input  8  byte-stream data
- in_ready  output  1  loader can accept a byte
- wr_en  output  1  instruction memory write strobe
- wr_addr  output  ADDR_W  instruction memory word address
- wr_data  output  32  instruction word
- core_reset_n  output  1  low holds the pipeline in reset
- done  output  1  image loaded and verified
- error  output  1  load failed
- word_count  output  16  words written in the current load

Behaviour:
- Reset values (reset low): state IDLE; in_ready=0, wr_en=0, wr_addr=0, wr_data=0, core_reset_n=0, done=0, error=0, word_count=0, internal checksum and byte counter cleared.
- Reset asserted mid-load: same values immediately, with no partial write in flight. Memory contents are unspecified until the next successful load.
- Frame format: LEN_LO, LEN_HI (N = 16-bit word count), then 4*N payload bytes with the LSB first within each word, then CHK. CHK is the XOR of every preceding byte in the frame, including the length bytes.
- A byte is accepted when in_valid & in_ready on a rising edge. The sender must hold in_data stable while in_valid=1 and in_ready=0.
- in_ready=1 only in states LEN0, LEN1, DATA and CHK.
- States:
  - IDLE: start -> LEN0. Clears checksum, word_count and wr_addr; drives core_reset_n=0, done=0, error=0.
  - LEN0: accept LEN_LO -> LEN1.
  - LEN1: accept LEN_HI, then:
    - N > 2^ADDR_W -> ERROR.
    - N == 0 -> CHK.
    - otherwise -> DATA.
  - DATA: a 2-bit byte lane counter shifts bytes into the word.
    - On the 4th byte, wr_en pulses for exactly one cycle in the following cycle, with wr_addr = word index and wr_data = the assembled word.
    - word_count increments in that same cycle; wr_addr advances after the write.
    - After word N-1 is accepted -> CHK.
  - CHK: accept CHK. If the running XOR matches -> DONE, else -> ERROR.
  - DONE: done=1, core_reset_n=1; stays here until start.
  - ERROR: error=1, core_reset_n=0; stays here until start.
- start in DONE or ERROR re-enters LEN0 and drops core_reset_n in the same edge. start in any other state is ignored.
- done and error are never 1 simultaneously.
- No write occurs for N=0.
- The last address written is N-1. wr_addr never wraps because N is bounded at 2^ADDR_W.
- All outputs are registered.

Optional Feature:
- Macro: IMEM_LOADER_TIMEOUT_EN.
- Defined: a 16-bit idle counter runs in LEN0, LEN1, DATA and CHK. It clears on each accepted byte and on state entry. When it reaches TIMEOUT_CYCLES with no accepted byte, the loader goes to ERROR on the next edge.
- Undefined: no counter is built, and the loader waits indefinitely in any state.

Test Plan:
- Good load, ADDR_W=8:
  - Stimulus: start, then bytes 02 00 13 01 50 00 93 01 C0 00 12.
  - Response: wr_en pulses twice, (addr 0, 0x00500113) then (addr 1, 0x00C00193); word_count=2; done=1, core_reset_n=1, error=0.
- Bad checksum: same frame with CHK=13 -> both writes still occur; error=1, done=0, core_reset_n stays 0; in_ready=0 afterwards.
- Empty image: start, then bytes 00 00 00 -> no wr_en; done=1; word_count=0.
- Oversize image: N=0x0101 with ADDR_W=8 -> ERROR on the edge after LEN_HI is accepted; no wr_en; in_ready=0.
- Backpressure and reset mid-load:
  - Good frame from the first test with in_valid randomly deasserted -> identical writes and done.
  - Repeat, pulling reset low after 5 bytes -> all outputs return to reset values immediately.
  - Then start plus a full good frame -> done=1.
- Timeout, with IMEM_LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=16:
  - Stall after 3 bytes -> error=1 exactly 16 cycles after the last accepted byte, plus one edge.
  - Same stimulus without the macro -> loader remains in DATA with error=0.
